pc_fetch_controller: RTL

- Owns the program counter and sequences instruction fetch into the IF/ID stage.
- Chooses the next PC by priority: exception vector, then the branch/jump target resolved in ID, then PC+4.
- Runs a req/ack handshake with instruction memory and holds delivered instructions under hazard stalls.
- Drops wrong-path instructions on redirect. It supersedes the standalone next-PC mux in the pipeline top level.

---
 rtl/pc_fetch_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: program counter ownership and instruction fetch sequencing.
// Next-PC priority: exception vector, then ID-stage branch/jump target, then PC+4.
// Runs a single-outstanding req/ack handshake with instruction memory and holds
// the delivered instruction for IF/ID while the hazard unit stalls.
module pc_fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exc_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_r, pc_n;
    logic        if_valid_r, if_valid_n;
    logic [31:0] if_instr_r, if_instr_n;
    logic [31:0] if_pc_r, if_pc_n;
    logic        redir_pend, redir_pend_n;
    logic [31:0] redir_pc, redir_pc_n;

    logic        redir_now;
    logic [31:0] redir_src;
    logic [31:0] redir_addr;

    // Redirect source selection: exception beats branch; address word-aligned.
    always_comb begin
        redir_now  = exc_req | branch_taken;
        redir_src  = exc_req ? EXC_VECTOR : branch_target;
        redir_addr = redir_src & ALIGN_MASK;
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc_r       <= RESET_PC;
            if_valid_r <= 1'b0;
            if_instr_r <= '0;
            if_pc_r    <= '0;
            redir_pend <= 1'b0;
            redir_pc   <= '0;
        end else begin
            state      <= state_n;
            pc_r       <= pc_n;
            if_valid_r <= if_valid_n;
            if_instr_r <= if_instr_n;
            if_pc_r    <= if_pc_n;
            redir_pend <= redir_pend_n;
            redir_pc   <= redir_pc_n;
        end
    end

    // Next-state and next-datapath logic for the fetch sequencer.
    always_comb begin
        state_n      = state;
        pc_n         = pc_r;
        if_valid_n   = if_valid_r;
        if_instr_n   = if_instr_r;
        if_pc_n      = if_pc_r;
        redir_pend_n = redir_pend;
        redir_pc_n   = redir_pc;

        case (state)
            IDLE: begin
                // A redirect seen while idle retargets the upcoming fetch.
                if (redir_now) begin
                    pc_n = redir_addr;
                end
                state_n = FETCH;
            end

            FETCH: begin
                if (imem_ack) begin
                    if (redir_now) begin
                        // Same-cycle redirect beats any pending one; data is wrong-path.
                        pc_n         = redir_addr;
                        redir_pend_n = 1'b0;
                        state_n      = IDLE;
                    end else if (redir_pend) begin
                        pc_n         = redir_pc;
                        redir_pend_n = 1'b0;
                        state_n      = IDLE;
                    end else begin
                        if_instr_n = imem_data;
                        if_pc_n    = pc_r;
                        if_valid_n = 1'b1;
                        pc_n       = pc_r + 32'd4;
                        state_n    = DELIVER;
                    end
                end else if (redir_now) begin
                    // Request cannot be withdrawn: remember where to go once it returns.
                    redir_pend_n = 1'b1;
                    redir_pc_n   = redir_addr;
                end
            end

            DELIVER: begin
                if (redir_now) begin
                    if_valid_n = 1'b0;
                    pc_n       = redir_addr;
                    state_n    = FETCH;
                end else if (!stall) begin
                    if_valid_n = 1'b0;
                    state_n    = FETCH;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output drive: request only in FETCH; fetch address is the aligned PC.
    always_comb begin
        imem_req  = (state == FETCH);
        imem_addr = pc_r & ALIGN_MASK;
        if_valid  = if_valid_r;
        if_instr  = if_instr_r;
        if_pc     = if_pc_r;
        pc        = pc_r;
    end

endmodule
